out_drain_ctrl: RTL and testbench
=================================

Name: out_drain_ctrl

Overview:
- Parametrised successor to the single-bank output controller.
- Captures all F_NUM core accumulator sums on each kernel finish into one of two ping-pong shadow banks, then serialises them to the dst buffer.
- Uses a ready/strobe handshake and generates channel-major addresses.
- Double buffering lets the next kernel window run while the previous one drains; out_busy back-pressures sample control only when both banks are occupied.

Parameters:
- F_NUM, 16, number of filter cores/channels
- DW, 16, signed fixed-point sum width
- OD_W, 5, width of od (must hold F_NUM)
- OS_W, 10, width of os and the position counter
- OA_W, 12, dst address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous restart (driven by ~run); same effect as reset
- s_init  in  1  sample start; position counter := 0
- k_fin  in  1  pulse; sum_in valid this cycle
- sum_in  in  F_NUM*DW  channel i at bits [i*DW +: DW]
- od  in  OD_W  active channel count, 1..F_NUM; static while running
- os  in  OS_W  positions per channel, >=1; static while running
- out_ready  in  1  dst buffer accepts a write
- outr  out  1  write strobe
- oa  out  OA_W  write address = ch*os + pos
- x  out  DW  write data
- out_busy  out  1  both banks full
- ovf  out  1  sticky: a k_fin was dropped

Behaviour:
- Reset / clr: outr=0, oa=0, x=0, out_busy=0, ovf=0, both banks empty, pos=0, FSM IDLE, write pointer and read pointer = bank 0.
- Each bank holds F_NUM words, a pos tag and a full flag.
- Capture (k_fin=1):
  - If the write-pointer bank is free, load sum_in and tag=pos into it, set full, toggle the write pointer.
  - pos increments and wraps from os-1 to 0.
  - If both banks are full, the k_fin is dropped, pos is unchanged and ovf is set.
  - Exception: when the draining bank releases in the same cycle, the capture is accepted into that bank.
- s_init: pos:=0 only. Banks already captured keep their latched tags. s_init and k_fin in the same cycle: capture uses the old pos, then pos:=1 (or 0 if os==1).
- FSM states:
  - IDLE -> DRAIN when the read-pointer bank is full.
  - DRAIN: ch counts 0..od-1. outr=1, x=bank[ch], oa=base+tag, where base advances by os per channel (no multiplier).
  - Handshake: outr/oa/x are held stable while out_ready=0. On outr&out_ready, advance ch.
  - At ch==od-1, release the bank (full:=0) and toggle the read pointer. Go back to DRAIN if the other bank is full (no bubble), else IDLE.
- Latency: k_fin at cycle t into an idle block gives outr=1 with channel 0 at t+1. A continuously ready sink sees one write per cycle and od writes per window.
- out_busy is registered: 1 when both banks are full after this cycle's update. It is low again in the cycle after the release.
- Arithmetic: oa wraps mod 2^OA_W; no range check.
- od>F_NUM is undefined.

Optional Feature:
- OUT_RELU_EN defined: at capture, any negative channel value (MSB=1) is stored as 0. Latency is unchanged.
- Not defined: values are stored unmodified.

Decomposition:
- Package out_drain_pkg holds the FSM state typedef (IDLE, DRAIN) and the default parameter constants.
- One sub-module, drain_bank: F_NUM×DW register file, tag, full flag, load/release ports, and a combinational read by channel index. Instantiate two.

Test Plan:
- od=4, os=3, out_ready=1, three k_fin 1 cycle apart with sums ch=i*10+window → 12 writes, oa order 0,3,6,9,1,4,7,10,2,5,8,11, data matches, ovf=0.
- out_ready=0 for 5 cycles mid-drain → outr, oa and x held constant; no write lost or duplicated.
- out_ready=0, k_fin ×3 → out_busy=1 after the 2nd k_fin, 3rd dropped, ovf=1; release yields exactly 2×od writes with tags 0,1.
- Both banks full, k_fin coincident with the last handshake of the draining bank → capture accepted, ovf stays 0.
- s_init after 2 k_fin (os=5) while bank 0 is draining → bank 0 writes keep tag 0, next capture uses pos 0.
- OUT_RELU_EN: sum=-7 on ch 2 → x=0 at oa=2*os+pos; without the macro x=-7. clr mid-drain → outr=0 next cycle, banks empty.

Source files
------------

// File: rtl/out_drain_pkg.sv
// Shared types and default sizing for the two-bank output drain controller.
package out_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int F_NUM_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int OD_W_DEF  = 5;
    localparam int OS_W_DEF  = 10;
    localparam int OA_W_DEF  = 12;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_drain_ctrl_bank.sv
// One shadow bank: F_NUM x DW sum registers, position tag and full flag,
// read combinationally by channel index.
module drain_bank
    import out_drain_pkg::*;
#(
    parameter int F_NUM = F_NUM_DEF,
    parameter int DW    = DW_DEF,
    parameter int OS_W  = OS_W_DEF,
    parameter int CH_W  = ch_w(F_NUM_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    rel,
    input  logic [F_NUM*DW-1:0]     wr_data,
    input  logic [OS_W-1:0]         wr_tag,
    input  logic [CH_W-1:0]         rd_ch,
    output logic signed [DW-1:0]    rd_data,
    output logic [OS_W-1:0]         tag,
    output logic                    full
);

    logic signed [DW-1:0] mem [F_NUM];

    // A load coinciding with a release of the same bank leaves it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (rel) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            tag <= wr_tag;
            for (int i = 0; i < F_NUM; i++) begin
                mem[i] <= wr_data[i*DW +: DW];
            end
        end
    end

    assign rd_data = mem[rd_ch];

endmodule

// File: rtl/out_drain_ctrl.sv
// Ping-pong output drain: captures all core sums on k_fin, serialises them
// channel-major to the dst buffer. Define OUT_RELU_EN to clamp negatives at capture.
module out_drain_ctrl
    import out_drain_pkg::*;
#(
    parameter int F_NUM = F_NUM_DEF,
    parameter int DW    = DW_DEF,
    parameter int OD_W  = OD_W_DEF,
    parameter int OS_W  = OS_W_DEF,
    parameter int OA_W  = OA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    s_init,
    input  logic                    k_fin,
    input  logic [F_NUM*DW-1:0]     sum_in,
    input  logic [OD_W-1:0]         od,
    input  logic [OS_W-1:0]         os,
    input  logic                    out_ready,
    output logic                    outr,
    output logic [OA_W-1:0]         oa,
    output logic signed [DW-1:0]    x,
    output logic                    out_busy,
    output logic                    ovf
);

    localparam int CH_W = ch_w(F_NUM);

    state_t                 state, state_nxt;
    logic [OD_W-1:0]        ch, ch_nxt;
    logic [OA_W-1:0]        base, base_nxt;
    logic [OS_W-1:0]        pos, pos_nxt, pos_inc;
    logic                   wr_ptr, wr_ptr_nxt;
    logic                   rd_ptr, rd_ptr_nxt;
    logic                   ovf_nxt, busy_nxt;
    logic                   hs, rel_any, wr_free, accept;
    logic [1:0]             full, full_nxt, load, rel;
    logic [OS_W-1:0]        tag [2];
    logic signed [DW-1:0]   rd_data [2];
    logic [F_NUM*DW-1:0]    cap_data;

    function automatic logic [F_NUM*DW-1:0] relu_vec(input logic [F_NUM*DW-1:0] v);
        logic [F_NUM*DW-1:0] r;
        r = v;
`ifdef OUT_RELU_EN
        for (int i = 0; i < F_NUM; i++) begin
            if (v[i*DW + DW - 1]) begin
                r[i*DW +: DW] = '0;
            end
        end
`endif
        return r;
    endfunction

    assign cap_data = relu_vec(sum_in);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        drain_bank #(
            .F_NUM (F_NUM),
            .DW    (DW),
            .OS_W  (OS_W),
            .CH_W  (CH_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .load    (load[b]),
            .rel     (rel[b]),
            .wr_data (cap_data),
            .wr_tag  (pos),
            .rd_ch   (ch[CH_W-1:0]),
            .rd_data (rd_data[b]),
            .tag     (tag[b]),
            .full    (full[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ch       <= '0;
            base     <= '0;
            pos      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            ovf      <= 1'b0;
            out_busy <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            ch       <= '0;
            base     <= '0;
            pos      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            ovf      <= 1'b0;
            out_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            ch       <= ch_nxt;
            base     <= base_nxt;
            pos      <= pos_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            ovf      <= ovf_nxt;
            out_busy <= busy_nxt;
        end
    end

    always_comb begin
        hs      = (state == DRAIN) && out_ready;
        rel_any = hs && (ch == od - 1'b1);
        rel     = '0;
        if (rel_any) begin
            rel[rd_ptr] = 1'b1;
        end

        // Both banks full implies wr_ptr == rd_ptr, so a same-cycle release frees the write bank.
        wr_free = !full[wr_ptr] || (rel_any && (rd_ptr == wr_ptr));
        accept  = k_fin && wr_free;
        load    = '0;
        if (accept) begin
            load[wr_ptr] = 1'b1;
        end
        full_nxt   = (full & ~rel) | load;
        busy_nxt   = &full_nxt;
        ovf_nxt    = ovf | (k_fin & ~wr_free);
        wr_ptr_nxt = accept ? ~wr_ptr : wr_ptr;

        pos_inc = (pos == os - 1'b1) ? '0 : pos + 1'b1;
        if (s_init) begin
            pos_nxt = (accept && (os != OS_W'(1))) ? OS_W'(1) : '0;
        end else if (accept) begin
            pos_nxt = pos_inc;
        end else begin
            pos_nxt = pos;
        end

        state_nxt  = state;
        ch_nxt     = ch;
        base_nxt   = base;
        rd_ptr_nxt = rd_ptr;
        case (state)
            IDLE: begin
                if (full_nxt[rd_ptr]) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rel_any) begin
                    ch_nxt     = '0;
                    base_nxt   = '0;
                    rd_ptr_nxt = ~rd_ptr;
                    state_nxt  = full_nxt[rd_ptr_nxt] ? DRAIN : IDLE;
                end else if (hs) begin
                    ch_nxt   = ch + 1'b1;
                    base_nxt = base + OA_W'(os);
                end
            end
            default: state_nxt = IDLE;
        endcase

        outr = (state == DRAIN);
        oa   = outr ? base + OA_W'(tag[rd_ptr]) : '0;
        x    = outr ? rd_data[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_out_drain_ctrl.sv
// Randomised and directed bench for out_drain_ctrl against a window-queue reference model.
module tb_out_drain_ctrl;

    localparam int F   = 16;
    localparam int DW  = 16;
    localparam int ODW = 5;
    localparam int OSW = 10;
    localparam int OAW = 12;

    logic                  clk = 1'b0;
    logic                  rst_n, clr, s_init, k_fin, out_ready;
    logic [F*DW-1:0]       sum_in;
    logic [ODW-1:0]        od;
    logic [OSW-1:0]        os;
    logic                  outr, out_busy, ovf;
    logic [OAW-1:0]        oa;
    logic signed [DW-1:0]  x;

    always #5 clk = ~clk;

    out_drain_ctrl #(.F_NUM(F), .DW(DW), .OD_W(ODW), .OS_W(OSW), .OA_W(OAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_init    (s_init),
        .k_fin     (k_fin),
        .sum_in    (sum_in),
        .od        (od),
        .os        (os),
        .out_ready (out_ready),
        .outr      (outr),
        .oa        (oa),
        .x         (x),
        .out_busy  (out_busy),
        .ovf       (ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // A captured window: data, position tag and number of channels already written.
    typedef struct packed {
        logic [F*DW-1:0] d;
        int              tag;
        int              done;
    } win_t;

    win_t mq[$];
    int   m_pos;
    bit   m_ovf, m_busy;
    int   log_oa[$];
    int   log_x[$];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [F*DW-1:0] m_relu(input logic [F*DW-1:0] v);
        logic [F*DW-1:0] r;
        r = v;
`ifdef OUT_RELU_EN
        for (int i = 0; i < F; i++) begin
            if ($signed(v[i*DW +: DW]) < 0) r[i*DW +: DW] = '0;
        end
`endif
        return r;
    endfunction

    function automatic logic [F*DW-1:0] rnd_sum();
        logic [F*DW-1:0] r;
        for (int i = 0; i < F; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic check_outputs();
        win_t h;
        chk("outr", outr, mq.size() > 0);
        if (mq.size() > 0) begin
            h = mq[0];
            chk("oa", oa, (h.done * os + h.tag) % (1 << OAW));
            chk("x", x, $signed(h.d[h.done*DW +: DW]));
        end
        chk("out_busy", out_busy, m_busy);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic model_step(input bit k, input bit si, input bit rdy,
                              input logic [F*DW-1:0] s, input bit c);
        bit   hs, rel, acc;
        win_t h, w;
        if (c) begin
            mq.delete();
            m_pos  = 0;
            m_ovf  = 0;
            m_busy = 0;
            return;
        end
        hs  = (mq.size() > 0) && rdy;
        rel = hs && (mq[0].done == int'(od) - 1);
        acc = k && ((mq.size() < 2) || rel);
        if (hs) begin
            h = mq[0];
            h.done++;
            if (rel) void'(mq.pop_front());
            else mq[0] = h;
        end
        if (acc) begin
            w.d    = m_relu(s);
            w.tag  = m_pos;
            w.done = 0;
            mq.push_back(w);
        end
        if (k && !acc) m_ovf = 1;
        if (si) m_pos = acc ? (1 % int'(os)) : 0;
        else if (acc) m_pos = (m_pos + 1) % int'(os);
        m_busy = (mq.size() == 2);
    endtask

    // One clock: check current outputs, drive inputs, advance the model.
    task automatic tick(input bit k, input bit si, input bit rdy,
                        input logic [F*DW-1:0] s, input bit c);
        check_outputs();
        k_fin = k; s_init = si; out_ready = rdy; sum_in = s; clr = c;
        if (outr && rdy && !c) begin
            log_oa.push_back(int'(oa));
            log_x.push_back(int'(x));
        end
        model_step(k, si, rdy, s, c);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 0, rdy, '0, 0);
    endtask

    task automatic restart(input int new_od, input int new_os);
        tick(0, 0, 0, '0, 1);
        od = ODW'(new_od);
        os = OSW'(new_os);
        log_oa.delete();
        log_x.delete();
    endtask

    initial begin
        logic [F*DW-1:0] s;
        int exp1 [12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};

        rst_n = 1'b0; clr = 1'b0; s_init = 1'b0; k_fin = 1'b0; out_ready = 1'b0;
        sum_in = '0; od = 4; os = 3;
        m_pos = 0; m_ovf = 0; m_busy = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_outr", outr, 0);
        chk("rst_oa", oa, 0);
        chk("rst_x", x, 0);
        chk("rst_busy", out_busy, 0);
        chk("rst_ovf", ovf, 0);

        // Three windows, channel i = i*10 + window.
        restart(4, 3);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < F; i++) s[i*DW +: DW] = DW'(i * 10 + w);
            tick(1, 0, 1, s, 0);
            tick(0, 0, 1, '0, 0);
        end
        idle(10, 1);
        chk("p1_cnt", log_oa.size(), 12);
        if (log_oa.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("p1_oa", log_oa[i], exp1[i]);
                chk("p1_x", log_x[i], (i % 4) * 10 + i / 4);
            end
        end
        chk("p1_ovf", ovf, 0);

        // Sink stalls mid-drain.
        restart(4, 3);
        tick(1, 0, 1, rnd_sum(), 0);
        tick(0, 0, 1, '0, 0);
        idle(5, 0);
        idle(6, 1);
        chk("p2_cnt", log_oa.size(), 4);
        if (log_oa.size() == 4)
            for (int i = 0; i < 4; i++) chk("p2_oa", log_oa[i], i * 3);

        // Overflow with sink blocked.
        restart(4, 3);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, rnd_sum(), 0);
        chk("p3_busy", out_busy, 1);
        chk("p3_ovf", ovf, 1);
        idle(12, 1);
        chk("p3_cnt", log_oa.size(), 8);
        if (log_oa.size() == 8)
            for (int i = 0; i < 8; i++) chk("p3_oa", log_oa[i], (i % 4) * 3 + i / 4);
        chk("p3_busy_end", out_busy, 0);

        // Capture coincident with the last handshake while both banks full.
        restart(2, 3);
        tick(1, 0, 0, rnd_sum(), 0);
        tick(1, 0, 0, rnd_sum(), 0);
        tick(0, 0, 1, '0, 0);
        tick(1, 0, 1, rnd_sum(), 0);
        chk("p4_ovf", ovf, 0);
        idle(8, 1);
        chk("p4_cnt", log_oa.size(), 6);
        if (log_oa.size() == 6)
            for (int i = 0; i < 6; i++) chk("p4_oa", log_oa[i], (i % 2) * 3 + i / 2);

        // s_init while bank 0 drains.
        restart(4, 5);
        tick(1, 0, 1, rnd_sum(), 0);
        tick(1, 0, 1, rnd_sum(), 0);
        tick(0, 1, 1, '0, 0);
        idle(2, 1);
        tick(1, 0, 1, rnd_sum(), 0);
        idle(12, 1);
        chk("p5_cnt", log_oa.size(), 12);
        if (log_oa.size() == 12)
            for (int i = 0; i < 12; i++)
                chk("p5_oa", log_oa[i], (i % 4) * 5 + ((i / 4 == 1) ? 1 : 0));

        // Negative value on channel 2.
        restart(4, 3);
        for (int i = 0; i < F; i++) s[i*DW +: DW] = DW'(100 + i);
        s[2*DW +: DW] = -16'sd7;
        tick(1, 0, 1, s, 0);
        idle(6, 1);
        chk("p6_cnt", log_oa.size(), 4);
        if (log_oa.size() >= 3) begin
            chk("p6_oa", log_oa[2], 6);
`ifdef OUT_RELU_EN
            chk("p6_x", log_x[2], 0);
`else
            chk("p6_x", log_x[2], -7);
`endif
        end

        // clr mid-drain.
        restart(8, 3);
        tick(1, 0, 1, rnd_sum(), 0);
        tick(1, 0, 1, rnd_sum(), 0);
        tick(0, 0, 1, '0, 0);
        tick(0, 0, 1, '0, 1);
        chk("p7_outr", outr, 0);
        chk("p7_busy", out_busy, 0);
        log_oa.delete();
        log_x.delete();
        idle(6, 1);
        chk("p7_cnt", log_oa.size(), 0);

        // Random traffic across configurations.
        for (int cfg = 0; cfg < 8; cfg++) begin
            restart($urandom_range(1, F), $urandom_range(1, 12));
            for (int n = 0; n < 400; n++)
                tick($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                     $urandom_range(0, 3) != 0, rnd_sum(), 0);
            idle(40, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
